// File: rtl/alu_ops_pkg.sv
// Opcode map and sequencer state encoding shared by alu_op_sequencer,
// Total_ALU and their testbenches.
package alu_ops_pkg;

    localparam logic [5:0] OP_AND  = 6'd36;
    localparam logic [5:0] OP_OR   = 6'd37;
    localparam logic [5:0] OP_ADD  = 6'd32;
    localparam logic [5:0] OP_SUB  = 6'd34;
    localparam logic [5:0] OP_SLT  = 6'd42;
    localparam logic [5:0] OP_SRL  = 6'd2;
    localparam logic [5:0] OP_DIVU = 6'd27;
    localparam logic [5:0] OP_MFHI = 6'd16;
    localparam logic [5:0] OP_MFLO = 6'd18;
    localparam logic [5:0] OP_NOP  = 6'd63;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPT,
        ST_DIV_RUN,
        ST_MFHI,
        ST_MFLO,
        ST_LO_CAP,
        ST_ERR,
        ST_RESP
    } seq_state_t;

    // Ops that finish in one ALU cycle; DIVU and the Hi/Lo moves are handled separately.
    function automatic logic is_single_op(input logic [5:0] op);
        logic single;
        single = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL: single = 1'b1;
            default: single = 1'b0;
        endcase
        return single;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Drives the shared Total_ALU one request at a time, hiding divider latency and
// the MFHI/MFLO moves behind a single valid/ready response.
module alu_op_sequencer #(
    parameter int         DIV_CYCLES = 33,
    parameter logic [5:0] NOP_CODE   = 6'd63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_hi,
    output logic        rsp_err,
    output logic [5:0]  alu_signal,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out
);
    import alu_ops_pkg::*;

    localparam int             CW       = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0]  DIV_LOAD = CW'(DIV_CYCLES - 1);

    seq_state_t    state;
    logic [CW-1:0] div_count;

    // req_ready comes up one cycle after reset releases, so a request can never
    // be accepted on the same edge that leaves reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            div_count  <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_hi     <= '0;
            rsp_err    <= 1'b0;
            alu_signal <= NOP_CODE;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        req_ready <= 1'b0;
                        alu_a     <= req_a;
                        alu_b     <= req_b;
                        rsp_data  <= '0;
                        rsp_hi    <= '0;
                        rsp_err   <= 1'b0;
                        if (is_single_op(req_op)) begin
                            alu_signal <= req_op;
                            state      <= ST_ISSUE;
                        end else if (req_op == OP_DIVU && req_b != '0) begin
                            alu_signal <= OP_DIVU;
                            div_count  <= DIV_LOAD;
                            state      <= ST_DIV_RUN;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_ISSUE: begin
                    alu_signal <= NOP_CODE;
                    state      <= ST_CAPT;
                end
                ST_CAPT: begin
                    rsp_data  <= alu_out;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_DIV_RUN: begin
                    if (div_count == '0) begin
                        alu_signal <= OP_MFHI;
                        state      <= ST_MFHI;
                    end else begin
                        div_count <= div_count - CW'(1);
                    end
                end
                ST_MFHI: begin
                    alu_signal <= OP_MFLO;
                    state      <= ST_MFLO;
                end
                // alu_out now carries Hi from the MFHI issued last cycle.
                ST_MFLO: begin
                    rsp_hi     <= alu_out;
                    alu_signal <= NOP_CODE;
                    state      <= ST_LO_CAP;
                end
                ST_LO_CAP: begin
                    rsp_data  <= alu_out;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_ERR: begin
                    rsp_err   <= 1'b1;
                    rsp_data  <= '0;
                    rsp_hi    <= '0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a registered Total_ALU stand-in
// and a spec-level response/latency model.
module tb_alu_op_sequencer;
    import alu_ops_pkg::*;

    localparam int         DIV_CYCLES = 33;
    localparam logic [5:0] NOP        = 6'd63;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_hi;
    logic        rsp_err;
    logic [5:0]  alu_signal;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic [31:0] alu_hi_reg;
    logic [31:0] alu_lo_reg;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [31:0] exp_data;
    logic [31:0] exp_hi;
    logic        exp_err;

    alu_op_sequencer #(.DIV_CYCLES(DIV_CYCLES), .NOP_CODE(NOP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hi(rsp_hi), .rsp_err(rsp_err),
        .alu_signal(alu_signal), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    // Stand-in for Total_ALU: result registered one cycle after inputs are applied.
    always @(posedge clk) begin
        if (reset) begin
            alu_out    <= '0;
            alu_hi_reg <= '0;
            alu_lo_reg <= '0;
        end else begin
            case (alu_signal)
                OP_ADD:  alu_out <= alu_a + alu_b;
                OP_SUB:  alu_out <= alu_a - alu_b;
                OP_AND:  alu_out <= alu_a & alu_b;
                OP_OR:   alu_out <= alu_a | alu_b;
                OP_SLT:  alu_out <= {31'd0, $signed(alu_a) < $signed(alu_b)};
                OP_SRL:  alu_out <= alu_a >> alu_b[4:0];
                OP_MFHI: alu_out <= alu_hi_reg;
                OP_MFLO: alu_out <= alu_lo_reg;
                OP_DIVU: begin
                    alu_out <= '0;
                    if (alu_b != '0) begin
                        alu_hi_reg <= alu_a % alu_b;
                        alu_lo_reg <= alu_a / alu_b;
                    end
                end
                default: alu_out <= '0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, actual, actual, expected, expected);
    endtask

    // What the requester must see, straight from the op definitions.
    task automatic modelResponse(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] d, output logic [31:0] h, output logic e,
                                 output int lat);
        d = '0; h = '0; e = 1'b0; lat = 2;
        case (op)
            OP_ADD: d = a + b;
            OP_SUB: d = a - b;
            OP_AND: d = a & b;
            OP_OR:  d = a | b;
            OP_SLT: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SRL: d = a >> b[4:0];
            OP_DIVU: begin
                if (b == 0) begin e = 1'b1; lat = 1; end
                else begin d = a / b; h = a % b; lat = DIV_CYCLES + 3; end
            end
            default: begin e = 1'b1; lat = 1; end
        endcase
    endtask

    // While a response is presented it must match the model, with the ALU idle and no new accept.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            checkOutput("rsp_data", rsp_data, exp_data);
            checkOutput("rsp_hi", rsp_hi, exp_hi);
            checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            checkOutput("resp_alu_nop", {26'd0, alu_signal}, {26'd0, NOP});
            checkOutput("resp_req_ready", {31'd0, req_ready}, 32'd0);
        end
    end

    task automatic waitReady(output logic ok);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ok = req_ready;
        if (!ok) checkOutput("req_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int hold, input logic [31:0] lit_data,
                                 input logic [31:0] lit_hi, input logic lit_err);
        logic       ok;
        int         lat;
        int         exp_lat;
        int         seq_errs;
        logic [5:0] seen[$];
        logic [5:0] want[$];
        waitReady(ok);
        if (!ok) return;
        modelResponse(op, a, b, exp_data, exp_hi, exp_err, exp_lat);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        checkOutput("busy_req_ready", {31'd0, req_ready}, 32'd0);
        while (!rsp_valid && lat < 200) begin
            seen.push_back(alu_signal);
            lat++;
            @(negedge clk);
        end
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        if (exp_err) want.push_back(NOP);
        else if (op == OP_DIVU) begin
            for (int i = 0; i < DIV_CYCLES; i++) want.push_back(OP_DIVU);
            want.push_back(OP_MFHI); want.push_back(OP_MFLO); want.push_back(NOP);
        end else begin
            want.push_back(op); want.push_back(NOP);
        end
        seq_errs = (seen.size() == want.size()) ? 0 : 1;
        for (int i = 0; i < seen.size() && i < want.size(); i++)
            if (seen[i] !== want[i]) seq_errs++;
        checkOutput("alu_signal_seq_errors", 32'(seq_errs), 32'd0);
        checkOutput("lit_data", rsp_data, lit_data);
        checkOutput("lit_hi", rsp_hi, lit_hi);
        checkOutput("lit_err", {31'd0, rsp_err}, {31'd0, lit_err});
        // A second request held during backpressure must be ignored.
        if (hold > 0) begin
            req_valid = 1'b1; req_op = OP_OR; req_a = 32'hFFFF; req_b = 32'h1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic ok;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        exp_data = '0; exp_hi = '0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_data", rsp_data, 32'd0);
        checkOutput("reset_rsp_hi", rsp_hi, 32'd0);
        checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        checkOutput("reset_alu_signal", {26'd0, alu_signal}, 32'd63);
        checkOutput("reset_alu_a", alu_a, 32'd0);
        checkOutput("reset_alu_b", alu_b, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", {31'd0, req_ready}, 32'd1);

        applyStimulus(OP_ADD, 32'd16, 32'd12, 0, 32'd28, 32'd0, 1'b0);
        applyStimulus(OP_SRL, 32'd16, 32'd2,  0, 32'd4,  32'd0, 1'b0);
        applyStimulus(OP_SLT, 32'd16, 32'd12, 0, 32'd0,  32'd0, 1'b0);
        applyStimulus(OP_SLT, 32'd12, 32'd16, 1, 32'd1,  32'd0, 1'b0);
        applyStimulus(OP_SLT, 32'hFFFFFFFF, 32'd1, 0, 32'd1, 32'd0, 1'b0);
        applyStimulus(OP_SUB, 32'd16, 32'd12, 0, 32'd4,  32'd0, 1'b0);
        applyStimulus(OP_SUB, 32'd5,  32'd7,  0, 32'hFFFFFFFE, 32'd0, 1'b0);
        applyStimulus(OP_AND, 32'd16, 32'd12, 0, 32'd0,  32'd0, 1'b0);
        applyStimulus(OP_OR,  32'd16, 32'd12, 0, 32'd28, 32'd0, 1'b0);
        applyStimulus(OP_DIVU, 32'd16,  32'd5, 0, 32'd3,  32'd1, 1'b0);
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 3, 32'd14, 32'd2, 1'b0);
        applyStimulus(OP_DIVU, 32'd16,  32'd0, 0, 32'd0,  32'd0, 1'b1);
        applyStimulus(6'd5,    32'd16, 32'd12, 0, 32'd0,  32'd0, 1'b1);
        applyStimulus(OP_MFHI, 32'd16, 32'd12, 0, 32'd0,  32'd0, 1'b1);
        applyStimulus(OP_NOP,  32'd16, 32'd12, 0, 32'd0,  32'd0, 1'b1);
        applyStimulus(OP_ADD, 32'd16, 32'd12, 10, 32'd28, 32'd0, 1'b0);

        // Abort a divide partway through DIV_RUN.
        waitReady(ok);
        if (ok) begin
            req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd16; req_b = 32'd5;
            @(posedge clk);
            #1 req_valid = 1'b0;
            repeat (10) @(negedge clk);
            checkOutput("div_run_signal", {26'd0, alu_signal}, {26'd0, OP_DIVU});
            reset = 1'b1;
            @(negedge clk);
            checkOutput("abort_alu_signal", {26'd0, alu_signal}, 32'd63);
            checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd0);
            checkOutput("abort_alu_a", alu_a, 32'd0);
            reset = 1'b0;
            @(negedge clk);
        end
        applyStimulus(OP_ADD, 32'd7, 32'd9, 0, 32'd16, 32'd0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequencing controller between command sources and the shared `Total_ALU` datapath. It accepts one operation at a time through a valid/ready request port and drives the ALU's `signal`/`dataA`/`dataB` inputs. For DIVU it holds the divide for its full multi-cycle duration, then issues MFHI and MFLO automatically. It returns a single response (result, or quotient/remainder) through a valid/ready response port, so requesters never handle divider timing or Hi/Lo moves.

## Interface
- `DIV_CYCLES`, default 33: cycles DIVU (27) is held on the ALU before Hi/Lo are readable.
- `NOP_CODE`, default 6'd63: ALU code driven whenever no operation is in flight.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept; high only in IDLE.
- `req_op`  in  6  ALU function code.
- `req_a`  in  32  operand A.
- `req_b`  in  32  operand B.
- `rsp_valid`  out  1  response present; held until accepted.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  32  result; for DIVU, Lo (quotient).
- `rsp_hi`  out  32  DIVU Hi (remainder); 0 for other ops.
- `rsp_err`  out  1  unsupported opcode or divide by zero.
- `alu_signal`  out  6  to ALU `signal`.
- `alu_a`  out  32  to ALU `dataA`.
- `alu_b`  out  32  to ALU `dataB`.
- `alu_out`  in  32  from ALU `dataOut`; registered, valid 1 cycle after inputs are applied.

## Operation
- Supported codes: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, DIVU 27. The sequencer uses MFHI 16 and MFLO 18 internally; requesters never issue them.
- A request is accepted on `req_valid && req_ready`. The op and operands are latched. `alu_a`/`alu_b` hold the latched operands until the response.
- States:
  - IDLE → ISSUE (single-cycle op), DIV_RUN (DIVU, b≠0), or ERR (bad op, or DIVU with b=0).
  - ISSUE: drive op for 1 cycle → CAPT.
  - CAPT: drive NOP; latch `alu_out` into `rsp_data` → RESP.
  - DIV_RUN: drive 27 for DIV_CYCLES cycles, counted by a down-counter → MFHI.
  - MFHI: drive 16 → MFLO.
  - MFLO: drive 18; latch `alu_out` into `rsp_hi` → LO_CAP.
  - LO_CAP: drive NOP; latch `alu_out` into `rsp_data` → RESP.
  - ERR: set `rsp_err`=1, data=0, hi=0 → RESP.
  - RESP: `rsp_valid`=1, all rsp fields stable; on `rsp_ready` → IDLE.
- Unsupported codes include 16, 18 and 63 when requested. DIVU with b=0 never reaches the ALU.
- `rsp_hi` is forced to 0 for non-DIVU ops.
- All arithmetic is performed by the ALU; the sequencer does no data manipulation.

## Timing
- Reset values: `req_ready`=0 while reset is high, then 1 in the first cycle after; `rsp_valid`=0, `rsp_data`=0, `rsp_hi`=0, `rsp_err`=0, `alu_signal`=NOP_CODE, `alu_a`=`alu_b`=0, state IDLE, counter 0.
- Single op: `rsp_valid` rises 2 cycles after the accept edge.
- DIVU: `rsp_valid` rises DIV_CYCLES+3 cycles after the accept edge (36 at default).
- Error path: `rsp_valid` rises 1 cycle after the accept edge.
- `req_ready` is low from the accept edge until the cycle after the response handshake. There is no back-to-back overlap; minimum initiation interval is 3 cycles.
- `rsp_valid` high with `rsp_ready` low: hold indefinitely, outputs stable, ALU at NOP.
- Reset mid-operation (including in DIV_RUN): abort, no response, all outputs return to reset values on the next edge. The ALU shares `reset`.
- `req_valid` while busy is ignored. The request must be held by the source until `req_ready`.

## Structure
- Shared package `alu_ops_pkg`: opcode localparams (AND, OR, ADD, SUB, SLT, SRL, DIVU, MFHI, MFLO, NOP) and the state enum. `Total_ALU` and its testbenches import the same codes.
- Single module; the DIV_RUN counter stays inline. `Total_ALU` is instantiated at the next level up, not inside.

## Test plan
- ADD a=16 b=12 → `rsp_data`=28, `rsp_hi`=0, `rsp_err`=0, `rsp_valid` 2 cycles after accept; `alu_signal` sequence 32, 63.
- SRL a=16 b=2 → 4; SLT a=16 b=12 → 0; SUB a=16 b=12 → 4; AND → 0; OR → 28, each at 2-cycle latency.
- DIVU a=16 b=5 → `rsp_data`=3, `rsp_hi`=1, `rsp_valid` at cycle 36; `alu_signal` = 27 ×33, 16, 18, 63.
- DIVU b=0 → `rsp_err`=1, data=0, hi=0 after 1 cycle; `alu_signal` stays 63 throughout. Op 5 → same error response.
- `rsp_ready` low 10 cycles after ADD → `rsp_valid` and data held stable, `req_ready`=0, second `req_valid` not accepted until handshake.
- `reset` asserted at cycle 10 of DIV_RUN → next cycle `alu_signal`=63, `rsp_valid`=0, `req_ready`=0; IDLE afterwards, and a fresh ADD completes correctly.
